// File: rtl/init_fill.sv
// init_fill: walks addresses 0..DEPTH-1 once per request and writes a
// mode-selected pattern into up to NUM_CH memory banks in parallel.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous, active-high reset
//   en        start request (IDLE); run qualifier in FILL when
//             INIT_FILL_PAUSE_EN is defined
//   mode      pattern select, captured at start
//               0 identity, 1 descending, 2 constant, 3 cnt ^ fill_val
//   fill_val  constant / xor operand, captured at start
//   ch_mask   banks to write, captured at start
//   rdy       high = idle, ready to accept en
//   addr      shared write address
//   wrdata    shared write data
//   wren      per-bank write enable
//
// Optional feature macro: INIT_FILL_PAUSE_EN
//   defined   : en=0 during FILL stalls the walk (wren=0, addr/wrdata held)
//   undefined : en is ignored during FILL
//
// state  | meaning
// S_RST  | in or just out of reset, all outputs 0
// S_IDLE | rdy=1, waiting for en
// S_FILL | walking the address range, one word per active cycle

module init_fill #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int NUM_CH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_val,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              rdy,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wrdata,
   output logic [NUM_CH-1:0] wren
);

   localparam logic [1:0] S_RST  = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] fill_q;
   logic [NUM_CH-1:0] mask_q;
   // act_q: the word currently on addr is a real write (not a stall cycle).
   // It is kept separately from wren because ch_mask may be 0.
   logic              act_q;
   logic [ADDR_W-1:0] cnt_nxt;
   logic              last;
   logic              run;

   function automatic logic [DATA_W-1:0] pattern(
      input logic [1:0]        m,
      input logic [DATA_W-1:0] f,
      input logic [ADDR_W-1:0] c
   );
      logic [31:0]       c32;
      logic [31:0]       d32;
      logic [DATA_W-1:0] res;
      c32 = 32'(c);
      d32 = 32'(DEPTH - 1) - c32;
      case (m)
         2'd0:    res = DATA_W'(c32);
         2'd1:    res = DATA_W'(d32);
         2'd2:    res = f;
         default: res = DATA_W'(c32) ^ f;
      endcase
      return res;
   endfunction

   // After a stall the held address has not been written yet, so the
   // counter only advances past a word that was actually written.
   assign cnt_nxt = act_q ? cnt + ADDR_W'(1) : cnt;
   assign last    = act_q && (cnt == LAST);

`ifdef INIT_FILL_PAUSE_EN
   assign run = en;
`else
   assign run = 1'b1;
`endif

   assign addr = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_RST;
         rdy    <= 1'b0;
         cnt    <= '0;
         wrdata <= '0;
         wren   <= '0;
         act_q  <= 1'b0;
         mode_q <= 2'd0;
         fill_q <= '0;
         mask_q <= '0;
      end else begin
         case (state)
            S_RST: begin
               state <= S_IDLE;
               rdy   <= 1'b1;
            end
            S_IDLE: begin
               if (en) begin
                  state  <= S_FILL;
                  rdy    <= 1'b0;
                  mode_q <= mode;
                  fill_q <= fill_val;
                  mask_q <= ch_mask;
                  cnt    <= '0;
                  act_q  <= 1'b1;
                  wrdata <= pattern(mode, fill_val, '0);
                  wren   <= ch_mask;
               end
            end
            S_FILL: begin
               if (last) begin
                  state  <= S_IDLE;
                  rdy    <= 1'b1;
                  cnt    <= '0;
                  act_q  <= 1'b0;
                  wrdata <= '0;
                  wren   <= '0;
               end else if (run) begin
                  cnt    <= cnt_nxt;
                  act_q  <= 1'b1;
                  wrdata <= pattern(mode_q, fill_q, cnt_nxt);
                  wren   <= mask_q;
               end else begin
                  // stall: wrdata keeps its last value
                  cnt    <= cnt_nxt;
                  act_q  <= 1'b0;
                  wren   <= '0;
               end
            end
            default: begin
               state  <= S_IDLE;
               rdy    <= 1'b1;
               cnt    <= '0;
               act_q  <= 1'b0;
               wrdata <= '0;
               wren   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_init_fill.sv
module tb_init_fill;

`ifdef INIT_FILL_PAUSE_EN
   localparam bit PAUSE = 1'b1;
`else
   localparam bit PAUSE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A: defaults (256 x 8, one bank)
   logic       en_a;
   logic [1:0] mode_a;
   logic [7:0] fill_a;
   logic [0:0] mask_a;
   logic       rdy_a;
   logic [7:0] addr_a;
   logic [7:0] wrdata_a;
   logic [0:0] wren_a;

   // instance B: 16 x 8, four banks
   logic       en_b;
   logic [1:0] mode_b;
   logic [7:0] fill_b;
   logic [3:0] mask_b;
   logic       rdy_b;
   logic [3:0] addr_b;
   logic [7:0] wrdata_b;
   logic [3:0] wren_b;

   init_fill u_a (
      .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .fill_val(fill_a),
      .ch_mask(mask_a), .rdy(rdy_a), .addr(addr_a), .wrdata(wrdata_a), .wren(wren_a)
   );

   init_fill #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .NUM_CH(4)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .fill_val(fill_b),
      .ch_mask(mask_b), .rdy(rdy_b), .addr(addr_b), .wrdata(wrdata_b), .wren(wren_b)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic [3:0] w;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_chk = 0;
   int   n_pass = 0;

   logic [7:0] mem_a[256];
   logic [7:0] mem_b[4][16];
   bit         wr_b[4][16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [7:0] exp_val(input logic [1:0] md, input logic [7:0] fv,
                                          input int i, input int depth);
      case (md)
         2'd0:    return 8'(i);
         2'd1:    return 8'(depth - 1 - i);
         2'd2:    return fv;
         default: return 8'(i) ^ fv;
      endcase
   endfunction

   task automatic clear_mems();
      for (int i = 0; i < 256; i++) mem_a[i] = 8'hEE;
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 16; i++) begin
            mem_b[b][i] = 8'hEE;
            wr_b[b][i]  = 1'b0;
         end
   endtask

   // scoreboard monitors: pop one expected word per observed write
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (wren_a !== 1'b0) begin
         if (q_a.size() == 0) check("sb_a_extra_write", 32'(addr_a), 32'hFFFF);
         else begin
            e = q_a.pop_front();
            check("sb_a_addr", 32'(addr_a), 32'(e.a));
            check("sb_a_data", 32'(wrdata_a), 32'(e.d));
         end
         mem_a[addr_a] = wrdata_a;
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (wren_b !== 4'b0000) begin
         if (q_b.size() == 0) check("sb_b_extra_write", 32'(addr_b), 32'hFFFF);
         else begin
            e = q_b.pop_front();
            check("sb_b_addr", 32'(addr_b), 32'(e.a[3:0]));
            check("sb_b_data", 32'(wrdata_b), 32'(e.d));
            check("sb_b_wren", 32'(wren_b), 32'(e.w));
         end
         for (int b = 0; b < 4; b++)
            if (wren_b[b]) begin
               mem_b[b][addr_b] = wrdata_b;
               wr_b[b][addr_b]  = 1'b1;
            end
      end
   end

   // One request. en stays high through the walk (dropped on the last write
   // cycle) except during the optional pause window [pause_at, pause_at+len).
   task automatic run(input bit sel, input logic [1:0] md, input logic [7:0] fv,
                      input logic [3:0] mk, input int pause_at, input int pause_len,
                      input int exp_lat, input string nm);
      int   depth;
      int   k;
      bit   done;
      bit   seen;
      bit   r;
      bit   w;
      exp_t e;
      depth = sel ? 16 : 256;
      for (int i = 0; i < depth; i++) begin
         e.a = 8'(i);
         e.d = exp_val(md, fv, i, depth);
         e.w = mk;
         if (sel) begin
            if (mk != 4'b0) q_b.push_back(e);
         end else if (mk[0]) q_a.push_back(e);
      end
      if (sel) begin
         mode_b = md; fill_b = fv; mask_b = mk; en_b = 1'b1;
      end else begin
         mode_a = md; fill_a = fv; mask_a = mk[0]; en_a = 1'b1;
      end
      @(posedge clk);
      #1;
      // operands must have been captured at the start edge
      if (sel) begin
         mode_b = ~md; fill_b = ~fv; mask_b = ~mk;
      end else begin
         mode_a = ~md; fill_a = ~fv; mask_a = ~mk[0];
      end
      k = 0; done = 1'b0; seen = 1'b0;
      while (!done && k < 2000) begin
         @(negedge clk);
         k++;
         r = sel ? rdy_b : rdy_a;
         w = sel ? (wren_b != 4'b0) : (wren_a != 1'b0);
         seen |= w;
         if (pause_len > 0 && k == pause_at + 10) begin
            check({nm, "_stall_addr"}, sel ? 32'(addr_b) : 32'(addr_a),
                  PAUSE ? 32'(pause_at) : 32'(pause_at + 9));
            check({nm, "_stall_wren"}, 32'(w), PAUSE ? 32'd0 : 32'd1);
         end
         if (r) done = 1'b1;
         else if (k >= pause_at && k < pause_at + pause_len) begin
            if (sel) en_b = 1'b0; else en_a = 1'b0;
         end else begin
            if (sel) en_b = (k < exp_lat - 1); else en_a = (k < exp_lat - 1);
         end
      end
      en_a = 1'b0;
      en_b = 1'b0;
      check({nm, "_latency"}, 32'(k), 32'(exp_lat));
      check({nm, "_any_wren"}, 32'(seen), 32'(mk != 4'b0));
      check({nm, "_sb_drained"}, sel ? 32'(q_b.size()) : 32'(q_a.size()), 32'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int bad;
      int k;
      exp_t e;
      rst = 1'b1;
      en_a = 1'b1; mode_a = 2'd0; fill_a = 8'h00; mask_a = 1'b1;
      en_b = 1'b1; mode_b = 2'd0; fill_b = 8'h00; mask_b = 4'hF;
      clear_mems();

      // reset held with en=1
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (rdy_a !== 1'b0 || addr_a !== 8'h00 || wrdata_a !== 8'h00 || wren_a !== 1'b0 ||
             rdy_b !== 1'b0 || addr_b !== 4'h0 || wrdata_b !== 8'h00 || wren_b !== 4'h0)
            bad++;
      end
      check("reset_hold_bad_cycles", 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
      @(negedge clk);
      check("rdy_before_first_edge", 32'(rdy_a), 32'd0);
      @(negedge clk);
      check("rdy_after_release_a", 32'(rdy_a), 32'd1);
      check("rdy_after_release_b", 32'(rdy_b), 32'd1);

      // identity fill, defaults
      clear_mems();
      run(1'b0, 2'd0, 8'h00, 4'b0001, 0, 0, 257, "a_identity");
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem_a[i] !== 8'(i)) bad++;
      check("a_identity_mem_bad", 32'(bad), 32'd0);

      // four banks, xor pattern, banks 1 and 3 only
      clear_mems();
      run(1'b1, 2'd3, 8'hA5, 4'b1010, 0, 0, 17, "b_xor");
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (mem_b[1][i] !== (8'(i) ^ 8'hA5)) bad++;
         if (mem_b[3][i] !== (8'(i) ^ 8'hA5)) bad++;
         if (wr_b[0][i] || wr_b[2][i]) bad++;
      end
      check("b_xor_mem_bad", 32'(bad), 32'd0);

      clear_mems();
      run(1'b1, 2'd1, 8'h00, 4'b1010, 0, 0, 17, "b_desc");
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (mem_b[1][i] !== 8'(15 - i)) bad++;
         if (mem_b[3][i] !== 8'(15 - i)) bad++;
         if (wr_b[0][i] || wr_b[2][i]) bad++;
      end
      check("b_desc_mem_bad", 32'(bad), 32'd0);

      // reset in the middle of a walk
      for (int i = 0; i < 256; i++) begin
         e.a = 8'(i); e.d = 8'(i); e.w = 4'b0001;
         q_a.push_back(e);
      end
      mode_a = 2'd0; fill_a = 8'h00; mask_a = 1'b1; en_a = 1'b1;
      @(posedge clk);
      #1;
      k = 0;
      while (k < 101) begin
         @(negedge clk);
         k++;
      end
      check("abort_at_write", 32'(addr_a), 32'd100);
      #2;
      rst = 1'b1;
      #1;
      check("abort_outputs_zero", {rdy_a, wren_a, wrdata_a, addr_a}, 32'd0);
      en_a = 1'b0;
      q_a.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_rdy_after_reset", 32'(rdy_a), 32'd1);

      clear_mems();
      run(1'b0, 2'd2, 8'h3C, 4'b0001, 0, 0, 257, "a_const");
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem_a[i] !== 8'h3C) bad++;
      check("a_const_mem_bad", 32'(bad), 32'd0);

      // en dropped for 20 cycles while addr 50 would be next
      clear_mems();
      run(1'b0, 2'd0, 8'h00, 4'b0001, 50, 20, PAUSE ? 277 : 257, "a_pause");
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem_a[i] !== 8'(i)) bad++;
      check("a_pause_mem_bad", 32'(bad), 32'd0);

      // empty mask: walk runs, no write enables
      clear_mems();
      run(1'b1, 2'd0, 8'h00, 4'b0000, 0, 0, 17, "b_nomask");

      // back-to-back with en held high: one idle cycle between fills
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 16; i++) begin
            e.a = 8'(i); e.d = 8'(i); e.w = 4'b1111;
            q_b.push_back(e);
         end
      mode_b = 2'd0; fill_b = 8'h00; mask_b = 4'b1111; en_b = 1'b1;
      @(posedge clk);
      #1;
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         k++;
         if (k == 17) check("b2b_idle_cycle_rdy", 32'(rdy_b), 32'd1);
         if (k == 18) check("b2b_restart_rdy", 32'(rdy_b), 32'd0);
         if (k == 33) en_b = 1'b0;
         if (k > 18 && rdy_b) break;
      end
      en_b = 1'b0;
      check("b2b_latency", 32'(k), 32'd34);
      check("b2b_sb_drained", 32'(q_b.size()), 32'd0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
